ow_cmd_receiver_p: RTL
======================

OW_CMD_RECEIVER_P -- requirements
Module: ow_cmd_receiver_p

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 8, data bits per frame (1..32).
REQ-002 SHALL have parameter SLOT_CYCLES, default 70, clk cycles per bit slot (>= SAMPLE_OFFSET+2).
REQ-003 SHALL have parameter SAMPLE_OFFSET, default 30, cycles from slot falling edge to bit sample (>= 1).
REQ-004 SHALL have parameter RESET_CYCLES, default 480, minimum bus-low cycles treated as a bus reset pulse (> SLOT_CYCLES).
REQ-005 SHALL have ports, in order: clk  input  1  single clock; one clock domain; reset is asynchronous and active-low.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 bus  inout  1  one-wire line; never driven by this block (held at z), only sampled.
REQ-008 en_cmd_recieve  input  1  level enable; low aborts and holds idle.
REQ-009 frame  output  FRAME_BITS  last completed frame, LSB received first.
REQ-010 done_recieving  output  1  one-cycle pulse when frame updates.
REQ-011 busy  output  1  high while a frame is partially received (bit count > 0 or slot in progress).
REQ-012 bus_reset  output  1  one-cycle pulse on detection of a reset pulse.

Function
REQ-013 SHALL pass bus through a 2-flop synchroniser; all edge detection, sampling and low-time counting use the synchronised value.
REQ-014 SHALL implement states IDLE, WAIT_SLOT, SAMPLE, RECOVER, DONE.
REQ-015 IDLE: en_cmd_recieve high -> WAIT_SLOT next cycle.
REQ-016 WAIT_SLOT: synchronised 1->0 transition -> SAMPLE, slot counter cleared to 0.
REQ-017 SAMPLE: slot counter increments each cycle; when it equals SAMPLE_OFFSET-1, bus is shifted in as {bus, sr[FRAME_BITS-1:1]}, bit count increments, -> RECOVER.
REQ-018 RECOVER: counter continues; at SLOT_CYCLES-1 -> DONE if bit count equals total bits, else WAIT_SLOT.
REQ-019 DONE: frame <= shift register, done_recieving high exactly this one cycle, bit count cleared, -> WAIT_SLOT if enabled, else IDLE.
REQ-020 Back-to-back frames SHALL be received without any gap beyond one slot recovery.
REQ-021 Bus-low counter saturates at RESET_CYCLES; on reaching it in any non-IDLE state: bus_reset pulses one cycle, bit count and shift register cleared, -> WAIT_SLOT after bus returns high; frame unchanged.
REQ-022 en_cmd_recieve low in any state -> IDLE next cycle, bit count cleared, no done_recieving, frame held.
REQ-023 en low coinciding with DONE: en has priority; frame not updated, no pulse.
REQ-024 Falling edges during SAMPLE/RECOVER SHALL be ignored (no re-sync mid-slot).
REQ-025 Slot counter width SHALL be $clog2(RESET_CYCLES+1); no wrap before saturation.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, counters 0, synchroniser flops 1, frame 0, done_recieving 0, busy 0, bus_reset 0, parity_err 0.
REQ-027 Reset mid-frame SHALL discard partial data; first frame after release starts from bit 0.

Configuration
REQ-028 Macro OW_RX_PARITY_EN defined: one extra even-parity bit is received after the data bits (total bits FRAME_BITS+1), output parity_err (1 bit) is added, registered in DONE as XOR of data and parity bit, held until next DONE; frame still updates.
REQ-029 Macro undefined: total bits = FRAME_BITS, no parity_err port, no parity logic.

Verification
REQ-030 Defaults, send 0xA5 LSB-first in 8 slots of 70 cycles -> frame=0xA5, done_recieving high exactly one cycle, busy low after.
REQ-031 Send 0x3C then 0xFF back-to-back -> two done pulses, frame 0x3C then 0xFF.
REQ-032 Three bits sent, then bus low 500 cycles, then 0x5A -> one bus_reset pulse, one done, frame=0x5A.
REQ-033 en_cmd_recieve dropped after bit 4 of 0x81 -> no done pulse, frame keeps prior value; re-enable and send 0x81 -> frame=0x81.
REQ-034 rst_n asserted after bit 5 -> all outputs 0 immediately; next full frame 0x12 received correctly.
REQ-035 OW_RX_PARITY_EN: 0xA5 with parity bit 0 -> parity_err=0; 0xA5 with parity bit 1 -> parity_err=1, frame=0xA5.

Source files
------------

// File: rtl/ow_cmd_receiver_p.sv
// ---------------------------------------------------------------------------
// ow_cmd_receiver_p
//
// Purpose: receive-only one-wire command slave. Each bit slot starts with a
// falling edge on the bus; the line level SAMPLE_OFFSET cycles later is the
// bit value (LSB first). A long low period is recognised as a bus reset.
//
// Ports:
//   clk             single clock
//   rst_n           asynchronous active-low reset
//   bus             one-wire line, sampled only (this block never drives it)
//   en_cmd_recieve  level enable; low aborts reception and holds idle
//   frame           last completed frame (FRAME_BITS wide)
//   done_recieving  one-cycle pulse in the cycle frame updates
//   busy            high while a frame is partially received
//   bus_reset       one-cycle pulse when a bus reset pulse is detected
//   parity_err      (OW_RX_PARITY_EN only) even-parity check of last frame
//
// Configuration macro: OW_RX_PARITY_EN adds a trailing even-parity bit to
// every frame and the parity_err output.
// ---------------------------------------------------------------------------
module ow_cmd_receiver_p #(
    parameter int FRAME_BITS    = 8,
    parameter int SLOT_CYCLES   = 70,
    parameter int SAMPLE_OFFSET = 30,
    parameter int RESET_CYCLES  = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inout  wire                   bus,
    input  logic                  en_cmd_recieve,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  done_recieving,
    output logic                  busy,
    output logic                  bus_reset
`ifdef OW_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef OW_RX_PARITY_EN
    localparam int TOTAL_BITS = FRAME_BITS + 1;
`else
    localparam int TOTAL_BITS = FRAME_BITS;
`endif
    localparam int CW        = $clog2(RESET_CYCLES + 1);
    localparam int BW        = $clog2(TOTAL_BITS + 1);
    // The counter reads 0 in the edge cycle, so its value is the number of
    // cycles elapsed since the synchronised falling edge.
    localparam int SAMPLE_AT = (SAMPLE_OFFSET > 1) ? (SAMPLE_OFFSET - 1) : 1;

    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1'b1);
    localparam logic [CW-1:0] SAMPLE_AT_C = CW'(SAMPLE_AT);
    localparam logic [CW-1:0] SLOT_LAST_C = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST_C  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LOW_SAT_C   = CW'(RESET_CYCLES);
    localparam logic [BW-1:0] BIT_ZERO    = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE     = BW'(1'b1);
    localparam logic [BW-1:0] TOTAL_C     = BW'(TOTAL_BITS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_SAMPLE    = 3'd2,
        ST_RECOVER   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_bus_prev;
    logic [CW-1:0]           r_low_cnt;
    logic [CW-1:0]           r_slot_cnt;
    logic [CW-1:0]           w_slot_nxt;
    logic [BW-1:0]           r_bit_cnt;
    logic [BW-1:0]           w_bit_nxt;
    logic [TOTAL_BITS-1:0]   r_sr;
    logic [TOTAL_BITS-1:0]   w_sr_nxt;
    logic [TOTAL_BITS-1:0]   w_sr_shift;
    logic [FRAME_BITS-1:0]   r_frame;
    logic [FRAME_BITS-1:0]   w_frame_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    r_bus_reset;
    logic                    w_bus_reset_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    w_fall;
    logic                    w_low_hit;
`ifdef OW_RX_PARITY_EN
    logic                    r_perr;
    logic                    w_perr_nxt;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_bus_prev <= 1'b1;
        end else begin
            r_sync1    <= bus;
            r_sync2    <= r_sync1;
            r_bus_prev <= r_sync2;
        end
    end

    assign w_fall    = r_bus_prev & ~r_sync2;
    // True in the single cycle where the low counter steps onto saturation.
    assign w_low_hit = ~r_sync2 & (r_low_cnt == LOW_LAST_C);

    // Bus-low duration counter, saturating so a held-low line pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_cnt <= CNT_ZERO;
        end else if (r_sync2) begin
            r_low_cnt <= CNT_ZERO;
        end else if (r_low_cnt != LOW_SAT_C) begin
            r_low_cnt <= r_low_cnt + CNT_ONE;
        end else begin
            r_low_cnt <= r_low_cnt;
        end
    end

    // New bit enters at the MSB so the first bit ends up at bit 0.
    if (TOTAL_BITS > 1) begin : g_shift
        assign w_sr_shift = {r_sync2, r_sr[TOTAL_BITS-1:1]};
    end else begin : g_shift_single
        assign w_sr_shift = r_sync2;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decode; enable beats bus reset beats slot timing.
    always_comb begin
        w_state_nxt     = r_state;
        w_slot_nxt      = r_slot_cnt;
        w_bit_nxt       = r_bit_cnt;
        w_sr_nxt        = r_sr;
        w_frame_nxt     = r_frame;
        w_done_nxt      = 1'b0;
        w_bus_reset_nxt = 1'b0;
`ifdef OW_RX_PARITY_EN
        w_perr_nxt      = r_perr;
`endif
        if (!en_cmd_recieve) begin
            w_state_nxt = ST_IDLE;
            w_slot_nxt  = CNT_ZERO;
            w_bit_nxt   = BIT_ZERO;
            w_sr_nxt    = {TOTAL_BITS{1'b0}};
        end else if (w_low_hit && (r_state != ST_IDLE)) begin
            // Bus is still low here, so WAIT_SLOT cannot see a new edge until
            // the line has returned high.
            w_bus_reset_nxt = 1'b1;
            w_state_nxt     = ST_WAIT_SLOT;
            w_slot_nxt      = CNT_ZERO;
            w_bit_nxt       = BIT_ZERO;
            w_sr_nxt        = {TOTAL_BITS{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT_SLOT;
                    w_slot_nxt  = CNT_ZERO;
                end
                ST_WAIT_SLOT: begin
                    if (w_fall) begin
                        w_state_nxt = ST_SAMPLE;
                        w_slot_nxt  = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_WAIT_SLOT;
                        w_slot_nxt  = CNT_ZERO;
                    end
                end
                ST_SAMPLE: begin
                    w_slot_nxt = r_slot_cnt + CNT_ONE;
                    if (r_slot_cnt == SAMPLE_AT_C) begin
                        w_sr_nxt    = w_sr_shift;
                        w_bit_nxt   = r_bit_cnt + BIT_ONE;
                        w_state_nxt = ST_RECOVER;
                    end else begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
                ST_RECOVER: begin
                    if (r_slot_cnt == SLOT_LAST_C) begin
                        w_slot_nxt = CNT_ZERO;
                        if (r_bit_cnt == TOTAL_C) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_WAIT_SLOT;
                        end
                    end else begin
                        w_slot_nxt  = r_slot_cnt + CNT_ONE;
                        w_state_nxt = ST_RECOVER;
                    end
                end
                ST_DONE: begin
                    w_frame_nxt = r_sr[FRAME_BITS-1:0];
                    w_done_nxt  = 1'b1;
`ifdef OW_RX_PARITY_EN
                    w_perr_nxt  = ^r_sr;
`endif
                    w_bit_nxt   = BIT_ZERO;
                    w_sr_nxt    = {TOTAL_BITS{1'b0}};
                    // DONE also serves as the first WAIT_SLOT cycle so a
                    // back-to-back frame's first edge is not lost.
                    if (w_fall) begin
                        w_state_nxt = ST_SAMPLE;
                        w_slot_nxt  = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_WAIT_SLOT;
                        w_slot_nxt  = CNT_ZERO;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_slot_nxt  = CNT_ZERO;
                    w_bit_nxt   = BIT_ZERO;
                    w_sr_nxt    = {TOTAL_BITS{1'b0}};
                end
            endcase
        end
    end

    assign w_busy_nxt = (w_bit_nxt != BIT_ZERO) ||
                        (w_state_nxt == ST_SAMPLE) ||
                        (w_state_nxt == ST_RECOVER);

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt  <= CNT_ZERO;
            r_bit_cnt   <= BIT_ZERO;
            r_sr        <= {TOTAL_BITS{1'b0}};
            r_frame     <= {FRAME_BITS{1'b0}};
            r_done      <= 1'b0;
            r_bus_reset <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_slot_cnt  <= w_slot_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_sr        <= w_sr_nxt;
            r_frame     <= w_frame_nxt;
            r_done      <= w_done_nxt;
            r_bus_reset <= w_bus_reset_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

`ifdef OW_RX_PARITY_EN
    // Parity result register, updated only when a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_nxt;
        end
    end

    assign parity_err = r_perr;
`endif

    assign frame          = r_frame;
    assign done_recieving = r_done;
    assign busy           = r_busy;
    assign bus_reset      = r_bus_reset;

endmodule
